// File: rtl/multiplicador_param.sv
// Sequential shift-add multiplier: unsigned shift-add or radix-2 Booth (signed),
// one step per clock over WIDTH cycles, with a 2*WIDTH-bit registered product.
module multiplicador_param #(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Signed,
  input  logic [WIDTH-1:0]   Multiplicando,
  input  logic [WIDTH-1:0]   Multiplicador,
  output logic [2*WIDTH-1:0] Produto,
  output logic               Busy,
  output logic               Done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_M;
  logic             r_S, r_E;
  logic [CW-1:0]    r_cnt;
  logic [2*WIDTH-1:0] r_prod;

  logic             w_accept, w_last;
  logic [WIDTH-1:0] w_upper, w_lower;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH-1:0] w_step;
  logic             w_e_next;

  assign w_accept = Start && (r_state != RUN);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_upper  = r_prod[2*WIDTH-1:WIDTH];
  assign w_lower  = r_prod[WIDTH-1:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (Start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = Start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Signed path works at WIDTH+1 bits so -2^(WIDTH-1) as multiplicand stays exact;
  // the extra bit becomes the retained sign after the arithmetic shift.
  always_comb begin
    if (!r_S) begin
      w_sum = {r_E, w_upper};
      if (r_prod[0]) w_sum = {1'b0, w_upper} + {1'b0, r_M};
    end else begin
      w_sum = {w_upper[WIDTH-1], w_upper};
      case ({r_prod[0], r_E})
        2'b01:   w_sum = {w_upper[WIDTH-1], w_upper} + {r_M[WIDTH-1], r_M};
        2'b10:   w_sum = {w_upper[WIDTH-1], w_upper} - {r_M[WIDTH-1], r_M};
        default: w_sum = {w_upper[WIDTH-1], w_upper};
      endcase
    end
  end

  assign w_step   = {w_sum, w_lower[WIDTH-1:1]};
  assign w_e_next = r_S ? r_prod[0] : 1'b0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_M    <= '0;
      r_S    <= 1'b0;
      r_E    <= 1'b0;
      r_cnt  <= '0;
      r_prod <= '0;
    end else if (w_accept) begin
      r_M    <= Multiplicando;
      r_S    <= Signed;
      r_E    <= 1'b0;
      r_cnt  <= '0;
      r_prod <= {{WIDTH{1'b0}}, Multiplicador};
    end else if (r_state == RUN) begin
      r_prod <= w_step;
      r_E    <= w_e_next;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign Produto = r_prod;
  assign Busy    = (r_state == RUN);
  assign Done    = (r_state == DONE);

endmodule

// File: tb/tb_multiplicador_param.sv
// Directed bench for multiplicador_param: WIDTH=16 and WIDTH=8 instances,
// vector table plus back-to-back, interference and mid-operation reset sequences.
module tb_multiplicador_param;

  logic        Clk, Reset_n;
  logic        st16, sg16, st8, sg8;
  logic [15:0] a16, b16;
  logic [7:0]  a8, b8;
  logic [31:0] p16;
  logic [15:0] p8;
  logic        bz16, dn16, bz8, dn8;

  int nchk = 0;
  int nerr = 0;

  multiplicador_param #(.WIDTH(16)) u16 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(st16), .Signed(sg16),
    .Multiplicando(a16), .Multiplicador(b16),
    .Produto(p16), .Busy(bz16), .Done(dn16)
  );

  multiplicador_param #(.WIDTH(8)) u8 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(st8), .Signed(sg8),
    .Multiplicando(a8), .Multiplicador(b8),
    .Produto(p8), .Busy(bz8), .Done(dn8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit          w8;
    bit          sg;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input bit w8, input bit sg, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp, input string nm);
    int  W, lat, bc;
    bit  got;
    W = w8 ? 8 : 16;
    @(negedge Clk);
    if (w8) begin st8 = 1'b1; sg8 = sg; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin st16 = 1'b1; sg16 = sg; a16 = a; b16 = b; end
    @(negedge Clk);
    st8 = 1'b0; st16 = 1'b0;
    chk({nm, " first-cycle"}, w8 ? {48'b0, p8} : {32'b0, p16},
        w8 ? {56'b0, b[7:0]} : {48'b0, b});
    chk({nm, " busy@1"}, w8 ? 64'(bz8) : 64'(bz16), 64'd1);
    lat = 1; bc = 1; got = 1'b0;
    while (lat < 60 && !got) begin
      @(negedge Clk);
      lat++;
      if (w8 ? dn8 : dn16) got = 1'b1;
      else if (w8 ? bz8 : bz16) bc++;
    end
    chk({nm, " done-seen"}, 64'(got), 64'd1);
    chk({nm, " latency"}, 64'(lat), 64'(W + 1));
    chk({nm, " busy-cycles"}, 64'(bc), 64'(W));
    chk({nm, " product"}, w8 ? {48'b0, p8} : {32'b0, p16}, {32'b0, exp});
    @(negedge Clk);
    chk({nm, " done-one-cycle"}, w8 ? 64'(dn8) : 64'(dn16), 64'd0);
    chk({nm, " hold"}, w8 ? {48'b0, p8} : {32'b0, p16}, {32'b0, exp});
  endtask

  vec_t vecs[$];

  initial begin
    int nd, dc;
    logic [31:0] pd;

    vecs.push_back('{0, 0, 16'd12,    16'd75,    32'h0000_0384});
    vecs.push_back('{0, 0, 16'hFFFF,  16'hFFFF,  32'hFFFE_0001});
    vecs.push_back('{0, 1, 16'hFFFF,  16'hFFFF,  32'h0000_0001});
    vecs.push_back('{0, 1, 16'h8000,  16'h8000,  32'h4000_0000});
    vecs.push_back('{0, 1, 16'hFFFD,  16'h0005,  32'hFFFF_FFF1});
    vecs.push_back('{0, 1, 16'h7FFF,  16'h8000,  32'hC000_8000});
    vecs.push_back('{0, 1, 16'h0003,  16'hFFFE,  32'hFFFF_FFFA});
    vecs.push_back('{0, 0, 16'h0000,  16'h1234,  32'h0000_0000});
    vecs.push_back('{0, 0, 16'h8000,  16'h0002,  32'h0001_0000});
    vecs.push_back('{0, 0, 16'h1234,  16'h0010,  32'h0001_2340});
    vecs.push_back('{1, 0, 16'h00FF,  16'h00FF,  32'h0000_FE01});
    vecs.push_back('{1, 1, 16'h0080,  16'h007F,  32'h0000_C080});
    vecs.push_back('{1, 1, 16'h0080,  16'h0080,  32'h0000_4000});
    vecs.push_back('{1, 0, 16'h0010,  16'h0010,  32'h0000_0100});

    Reset_n = 1'b0;
    st16 = 0; sg16 = 0; a16 = '0; b16 = '0;
    st8  = 0; sg8  = 0; a8  = '0; b8  = '0;
    repeat (2) @(negedge Clk);
    chk("reset p16", {32'b0, p16}, 64'd0);
    chk("reset busy16/done16", {62'b0, bz16, dn16}, 64'd0);
    chk("reset p8/busy8/done8", {46'b0, p8, bz8, dn8}, 64'd0);
    Reset_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].w8, vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    // back-to-back: Start raised in last RUN cycle and held through DONE
    @(negedge Clk);
    st16 = 1; sg16 = 0; a16 = 16'd3; b16 = 16'd4;
    @(negedge Clk);
    st16 = 0;
    repeat (15) @(negedge Clk);
    chk("b2b last-run busy", 64'(bz16), 64'd1);
    st16 = 1; a16 = 16'd16; b16 = 16'd5;
    @(negedge Clk);
    chk("b2b done1", 64'(dn16), 64'd1);
    chk("b2b prod1", {32'b0, p16}, 64'd12);
    @(negedge Clk);
    st16 = 0;
    chk("b2b re-accept busy", 64'(bz16), 64'd1);
    chk("b2b re-accept load", {32'b0, p16}, 64'd5);
    dc = 1;
    while (dc < 60 && !dn16) begin @(negedge Clk); dc++; end
    chk("b2b done2 spacing", 64'(dc), 64'd17);
    chk("b2b prod2", {32'b0, p16}, 64'h50);
    @(negedge Clk);

    // interference: Start pulses and operand changes in RUN cycles 3 and 10
    @(negedge Clk);
    st16 = 1; sg16 = 0; a16 = 16'h1234; b16 = 16'h0056;
    @(negedge Clk);
    st16 = 0;
    nd = 0; dc = 0; pd = '0;
    for (int c = 2; c <= 40; c++) begin
      @(negedge Clk);
      if (dn16) begin nd++; dc = c; pd = p16; end
      if (c == 3 || c == 10) begin
        st16 = 1; sg16 = 1; a16 = 16'(c * 16'h0111); b16 = 16'hF00D;
      end else begin
        st16 = 0;
      end
    end
    chk("intf done count", 64'(nd), 64'd1);
    chk("intf done cycle", 64'(dc), 64'd17);
    chk("intf product", {32'b0, pd}, 64'h0006_1D78);

    // reset in the middle of an operation
    @(negedge Clk);
    st16 = 1; sg16 = 0; a16 = 16'd12; b16 = 16'd75;
    @(negedge Clk);
    st16 = 0;
    repeat (6) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("midrst p16", {32'b0, p16}, 64'd0);
    chk("midrst busy/done", {62'b0, bz16, dn16}, 64'd0);
    nd = 0;
    repeat (3) begin @(negedge Clk); if (dn16) nd++; end
    Reset_n = 1'b1;
    repeat (20) begin @(negedge Clk); if (dn16) nd++; end
    chk("midrst no done", 64'(nd), 64'd0);
    run_op(0, 0, 16'd3, 16'd3, 32'd9, "post-reset 3x3");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
